instruction_fetch_stage: RTL

Instruction fetch stage of the pipelined CPU: owns the program counter, drives the address/enable side of the 256-byte instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. It sits directly upstream of decode and directly drives the instruction memory. It handles hazard stalls, taken-branch redirects with squash, and PC wrap-around. A misaligned branch target halts fetch.

---
 rtl/instruction_fetch_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory and
// captures the fetched word into the IF/ID register. A misaligned redirect halts fetch.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] InstData,
  output logic [31:0] InstAddress,
  output logic        InstEnable,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
  output logic        AlignFault,
  output logic [31:0] FetchCount
);

  // Keeps the PC inside the memory and word aligned in one AND.
  localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1) & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    count_d  = count_q;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        // A redirect wins over Stall so it is never dropped behind a hazard.
        if (BranchTaken) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (BranchTarget[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = BranchTarget & PC_MASK;
          end
        end else if (!Stall) begin
          instr_d = InstData;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4 & PC_MASK;
          count_d = count_q + 32'd1;
        end
      end
      HALT: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
      default: begin
        state_d = HALT;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC & PC_MASK;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign InstAddress       = pc_q;
  assign InstEnable        = (state_q == FETCH);
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PC4         = pc4_q;
  assign IF_ID_Valid       = valid_q;
  assign AlignFault        = fault_q;
  assign FetchCount        = count_q;

endmodule
